// File: rtl/seq_shifter_pkg.sv
// Shared types and helpers for the sequential shifter.
package seq_shifter_pkg;

  // Shift modes; encodings 3'b110 and 3'b111 are not named and act as pass.
  typedef enum logic [2:0] {
    SH_PASS = 3'b000,
    SH_LSL  = 3'b001,
    SH_LSR  = 3'b010,
    SH_ASR  = 3'b011,
    SH_ROR  = 3'b100,
    SH_ROL  = 3'b101
  } shift_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shifter_state_e;

  // True for modes that actually move bits.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    logic res;
    res = 1'b0;
    case (mode)
      SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_ROL: res = 1'b1;
      default:                                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Single-position combinational shift/rotate stage.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result
);

  // Move the operand by exactly one bit according to the mode.
  always_comb begin
    result = data;
    case (mode)
      SH_LSL:  result = {data[WIDTH-2:0], 1'b0};
      SH_LSR:  result = {1'b0, data[WIDTH-1:1]};
      SH_ASR:  result = {data[WIDTH-1], data[WIDTH-1:1]};
      SH_ROR:  result = {data[0], data[WIDTH-1:1]};
      SH_ROL:  result = {data[WIDTH-2:0], data[WIDTH-1]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock between two valid/ready handshakes.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_mode,
  input  logic [SHAMT_W-1:0] in_amount,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  shifter_state_e     state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   step_data;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .data   (data_q),
    .mode   (mode_q),
    .result (step_data)
  );

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out_data  = data_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = in_mode;
          if (!is_shift_mode(in_mode) || (in_amount == '0)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = in_amount;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand, mode and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= SH_PASS;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=16) against a whole-shift reference model.
module tb_seq_shifter;

  localparam int W = 16;
  localparam int MAXWAIT = 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [2:0]    in_mode;
  logic [3:0]    in_amount;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  int checks;
  int errors;

  seq_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_amount (in_amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole shift computed in one go from the mode rules.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [2:0] m,
                                         input int amt);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (m)
      3'd1: return d << amt;
      3'd2: return d >> amt;
      3'd3: return W'($signed(d) >>> amt);
      3'd4: begin dd = dd >> amt; return dd[W-1:0]; end
      3'd5: begin dd = dd << amt; return dd[2*W-1:W]; end
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] m, input int amt);
    if (m == 3'd0 || m > 3'd5 || amt == 0) return 1;
    return amt + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for out_valid; no handshake on the output side.
  task automatic do_op(input logic [W-1:0] d, input logic [2:0] m, input int amt,
                       output int lat, output logic [W-1:0] res, output int busy_cnt);
    int guard;
    guard = 0;
    while (!in_ready && guard < MAXWAIT) begin
      tick();
      guard++;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    in_amount = 4'(amt);
    tick();
    in_valid  = 1'b0;
    in_data   = W'($urandom);
    in_mode   = 3'($urandom);
    in_amount = 4'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < MAXWAIT) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy) busy_cnt++;
    res = out_data;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat, bc;
    logic [W-1:0] res;
    do_op(16'hF0CF, 3'd0, 0, lat, res, bc);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass_amount0();
    int lat, bc;
    logic [W-1:0] res;
    do_op(16'hF0CF, 3'd0, 7, lat, res, bc);
    checks++;
    if (lat !== 1 || res !== 16'hF0CF) begin
      errors++; $display("FAIL pass7 got lat=%0d data=%h want lat=1 data=f0cf", lat, res);
    end
    take_result();
    do_op(16'hF0CF, 3'd1, 0, lat, res, bc);
    checks++;
    if (lat !== 1 || res !== 16'hF0CF) begin
      errors++; $display("FAIL lsl0 got lat=%0d data=%h want lat=1 data=f0cf", lat, res);
    end
    take_result();
  endtask

  task automatic test_shifts();
    logic [2:0]   modes[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    int           amts [6] = '{4, 1, 3, 4, 4, 15};
    logic [W-1:0] exps [6] = '{16'h0CF0, 16'h7867, 16'hFE19, 16'hFF0C, 16'h0CFF, 16'hF867};
    int lat, bc;
    logic [W-1:0] res;
    for (int i = 0; i < 6; i++) begin
      do_op(16'hF0CF, modes[i], amts[i], lat, res, bc);
      checks++;
      if (res !== exps[i]) begin
        errors++; $display("FAIL shift_data[%0d] got %h want %h", i, res, exps[i]);
      end
      checks++;
      if (lat !== amts[i] + 1) begin
        errors++; $display("FAIL shift_latency[%0d] got %0d want %0d", i, lat, amts[i] + 1);
      end
      checks++;
      if (bc !== amts[i] + 1) begin
        errors++; $display("FAIL shift_busy[%0d] got %0d want %0d", i, bc, amts[i] + 1);
      end
      take_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exps[i]) begin
        errors++;
        $display("FAIL shift_release[%0d] got ov=%b ir=%b data=%h want ov=0 ir=1 data=%h",
                 i, out_valid, in_ready, out_data, exps[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, bc, guard;
    logic [W-1:0] res;
    do_op(16'hF0CF, 3'd2, 1, lat, res, bc);
    in_valid  = 1'b1;
    in_data   = 16'hF0CF;
    in_mode   = 3'd1;
    in_amount = 4'd1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h7867 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got ov=%b data=%h ir=%b want ov=1 data=7867 ir=0",
                 i, out_valid, out_data, in_ready);
      end
      tick();
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_idle got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept got busy=%b want 1", busy); end
    guard = 0;
    while (!out_valid && guard < MAXWAIT) begin
      tick();
      guard++;
    end
    checks++;
    if (guard !== 1 || out_data !== 16'hE19E) begin
      errors++; $display("FAIL bp_pending got wait=%0d data=%h want wait=1 data=e19e", guard, out_data);
    end
    take_result();
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    logic [W-1:0] res;
    logic seen;
    in_valid  = 1'b1;
    in_data   = 16'hF0CF;
    in_mode   = 3'd1;
    in_amount = 4'd10;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_valid got %b want 0", seen); end
    do_op(16'hF0CF, 3'd1, 1, lat, res, bc);
    checks++;
    if (res !== 16'hE19E || lat !== 2) begin
      errors++; $display("FAIL midreset_next got data=%h lat=%0d want data=e19e lat=2", res, lat);
    end
    take_result();
  endtask

  task automatic test_random();
    int lat, bc, amt, stall;
    logic [W-1:0] d, res, exp_d;
    logic [2:0] m;
    for (int i = 0; i < 40; i++) begin
      d   = W'($urandom);
      m   = 3'($urandom_range(0, 7));
      amt = $urandom_range(0, 15);
      exp_d = model(d, m, amt);
      do_op(d, m, amt, lat, res, bc);
      checks++;
      if (res !== exp_d || lat !== model_lat(m, amt)) begin
        errors++;
        $display("FAIL rand[%0d] d=%h m=%0d amt=%0d got data=%h lat=%0d want data=%h lat=%0d",
                 i, d, m, amt, res, lat, exp_d, model_lat(m, amt));
      end
      stall = $urandom_range(0, 2);
      repeat (stall) tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++;
        $display("FAIL rand_hold[%0d] got ov=%b data=%h want ov=1 data=%h", i, out_valid,
                 out_data, exp_d);
      end
      take_result();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    in_amount = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_pass_amount0();
    test_shifts();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
